// File: rtl/clk_dvdr_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Default half-period gives 1 Hz from a 40 MHz clk_in.
package clk_dvdr_pkg;

    localparam int CNT_W_DEFAULT        = 26;
    localparam int DEFAULT_HALF_1HZ_40M = 19_999_999;

    // Channel-select width that stays at least one bit for a single channel.
    function automatic int ch_width(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/clk_dvdr_chan.sv
// One divider channel: free-running count against an active half-period,
// with a shadow half-period that is only adopted at wrap, align or disable.
module clk_dvdr_chan
    import clk_dvdr_pkg::*;
#(
    parameter int               CNT_W        = CNT_W_DEFAULT,
    parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(DEFAULT_HALF_1HZ_40M)
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             align,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_half,
    output logic             divided_clk,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] active_half_reg, active_half_next;
    logic [CNT_W-1:0] shadow_half_reg, shadow_half_next;
    logic             shadow_pend_reg, shadow_pend_next;
    logic             level_reg, level_next;
    logic             tick_reg, tick_next;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg         <= '0;
            active_half_reg <= DEFAULT_HALF;
            shadow_half_reg <= DEFAULT_HALF;
            shadow_pend_reg <= 1'b0;
            level_reg       <= 1'b0;
            tick_reg        <= 1'b0;
        end else begin
            cnt_reg         <= cnt_next;
            active_half_reg <= active_half_next;
            shadow_half_reg <= shadow_half_next;
            shadow_pend_reg <= shadow_pend_next;
            level_reg       <= level_next;
            tick_reg        <= tick_next;
        end
    end

    always_comb begin
        cnt_next         = cnt_reg;
        active_half_next = active_half_reg;
        shadow_half_next = shadow_half_reg;
        shadow_pend_next = shadow_pend_reg;
        level_next       = level_reg;
        tick_next        = 1'b0;

        if (align || !en) begin
            cnt_next   = '0;
            level_next = 1'b0;
            if (shadow_pend_reg) begin
                active_half_next = shadow_half_reg;
                shadow_pend_next = 1'b0;
            end
        end else if (cnt_reg == active_half_reg) begin
            cnt_next   = '0;
            level_next = ~level_reg;
            tick_next  = 1'b1;
            if (shadow_pend_reg) begin
                active_half_next = shadow_half_reg;
                shadow_pend_next = 1'b0;
            end
        end else begin
            cnt_next = cnt_reg + CNT_W'(1);
        end

        // A write in the same cycle as an apply lands after it: the old shadow is
        // consumed and the new value waits for the following wrap.
        if (wr) begin
            shadow_half_next = wr_half;
            shadow_pend_next = 1'b1;
        end
    end

    assign divided_clk = level_reg;
    assign tick        = tick_reg;

endmodule

// File: rtl/multi_clk_dvdr.sv
// Multi-channel programmable clock divider: config decode, error strobe and
// NUM_CH independent divider channels.
module multi_clk_dvdr
    import clk_dvdr_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = CNT_W_DEFAULT,
    parameter int DEFAULT_HALF = DEFAULT_HALF_1HZ_40M,
    parameter int CH_W         = ch_width(NUM_CH)
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              align,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] divided_clk,
    output logic [NUM_CH-1:0] tick
);

    // One extra bit so NUM_CH itself is representable when it is a power of two.
    localparam logic [CH_W:0] NUM_CH_EXT = (CH_W + 1)'(NUM_CH);

    logic cfg_err_reg;
    logic ch_invalid;

    assign ch_invalid = ({1'b0, cfg_ch} >= NUM_CH_EXT);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_reg <= 1'b0;
        end else begin
            cfg_err_reg <= cfg_we && ch_invalid;
        end
    end

    assign cfg_err = cfg_err_reg;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
            logic wr;
            assign wr = cfg_we && (cfg_ch == CH_W'(gi));

            clk_dvdr_chan #(
                .CNT_W        (CNT_W),
                .DEFAULT_HALF (CNT_W'(DEFAULT_HALF))
            ) u_chan (
                .clk_in      (clk_in),
                .rst_n       (rst_n),
                .en          (ch_en[gi]),
                .align       (align),
                .wr          (wr),
                .wr_half     (cfg_half),
                .divided_clk (divided_clk[gi]),
                .tick        (tick[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_multi_clk_dvdr.sv
// Scoreboard bench for multi_clk_dvdr: a countdown reference model predicts
// every cycle's outputs; a monitor compares them after each rising edge.
module tb_multi_clk_dvdr;

    localparam int N   = 3;
    localparam int CW  = 6;
    localparam int DH  = 5;
    localparam int CHW = 2;

    logic           clk_in = 1'b0;
    logic           rst_n  = 1'b0;
    logic [N-1:0]   ch_en;
    logic           align;
    logic           cfg_we;
    logic [CHW-1:0] cfg_ch;
    logic [CW-1:0]  cfg_half;
    logic           cfg_err;
    logic [N-1:0]   divided_clk;
    logic [N-1:0]   tick;

    always #5 clk_in = ~clk_in;

    multi_clk_dvdr #(
        .NUM_CH       (N),
        .CNT_W        (CW),
        .DEFAULT_HALF (DH),
        .CH_W         (CHW)
    ) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .ch_en       (ch_en),
        .align       (align),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_half    (cfg_half),
        .cfg_err     (cfg_err),
        .divided_clk (divided_clk),
        .tick        (tick)
    );

    typedef struct {
        logic [N-1:0] dclk;
        logic [N-1:0] tk;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: cycles left until the next toggle, half-period in force,
    // and the queued half-period (-1 when nothing is pending).
    int m_left[N];
    int m_half[N];
    int m_pend[N];
    bit m_level[N];

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_left[c]  = DH;
            m_half[c]  = DH;
            m_pend[c]  = -1;
            m_level[c] = 1'b0;
        end
    endtask

    task automatic chk_reset(input string nm);
        checks++;
        if (divided_clk !== '0 || tick !== '0 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL %s got dclk=%b tick=%b err=%b required all zero",
                     nm, divided_clk, tick, cfg_err);
        end
    endtask

    // Drive one cycle of stimulus and push the outputs expected after the next edge.
    task automatic cyc(input logic [N-1:0] en, input logic al, input logic we,
                       input int ch, input int half);
        exp_t e;
        @(negedge clk_in);
        ch_en    = en;
        align    = al;
        cfg_we   = we;
        cfg_ch   = ch[CHW-1:0];
        cfg_half = half[CW-1:0];
        if (we) $display("cfg write ch=%0d half=%0d t=%0t", ch, half, $time);
        for (int c = 0; c < N; c++) begin
            e.tk[c] = 1'b0;
            if (al || !en[c]) begin
                if (m_pend[c] >= 0) begin m_half[c] = m_pend[c]; m_pend[c] = -1; end
                m_left[c]  = m_half[c];
                m_level[c] = 1'b0;
            end else if (m_left[c] == 0) begin
                m_level[c] = ~m_level[c];
                e.tk[c]    = 1'b1;
                if (m_pend[c] >= 0) begin m_half[c] = m_pend[c]; m_pend[c] = -1; end
                m_left[c]  = m_half[c];
            end else begin
                m_left[c]--;
            end
            if (we && ch == c) m_pend[c] = half;
            e.dclk[c] = m_level[c];
        end
        e.err = we && (ch >= N);
        sb.push_back(e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc('1, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_in);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (divided_clk !== e.dclk || tick !== e.tk || cfg_err !== e.err) begin
                    errors++;
                    if (errors <= 40)
                        $display("FAIL cycle t=%0t dclk=%b tick=%b err=%b required dclk=%b tick=%b err=%b",
                                 $time, divided_clk, tick, cfg_err, e.dclk, e.tk, e.err);
                end
            end
        end
    end

    initial begin : stim
        int guard;
        ch_en = '0; align = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_half = '0;
        model_reset();
        #3 chk_reset("reset_initial");
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_n = 1'b1;
        #1 chk_reset("reset_released");

        // Divide-by-8 on ch0, divide-by-2 on ch1, H=9 on ch2 (applied while disabled).
        cyc('0, 1'b0, 1'b1, 0, 3);
        cyc('0, 1'b0, 1'b1, 1, 0);
        cyc('0, 1'b0, 1'b1, 2, 9);
        run(40);

        // Reprogram ch2 to H=2 while its count sits at 5.
        guard = 0;
        while (m_left[2] != 4 && guard < 30) begin run(1); guard++; end
        cyc('1, 1'b0, 1'b1, 2, 2);
        run(30);

        // Write exactly on a ch0 wrap, then two writes before the next wrap.
        guard = 0;
        while (m_left[0] != 0 && guard < 30) begin run(1); guard++; end
        cyc('1, 1'b0, 1'b1, 0, 1);
        run(12);
        cyc('1, 1'b0, 1'b1, 0, 5);
        cyc('1, 1'b0, 1'b1, 0, 2);
        run(20);

        // Out-of-range channel.
        cyc('1, 1'b0, 1'b1, 3, 7);
        run(10);

        // Align mid-period: ch0/ch1 equal H, ch2 different.
        cyc('1, 1'b0, 1'b1, 0, 4);
        cyc('1, 1'b0, 1'b1, 1, 4);
        run(17);
        cyc('1, 1'b1, 1'b0, 0, 0);
        run(25);

        // Largest half-period on ch2, with a disable/re-enable in the middle.
        cyc('1, 1'b0, 1'b1, 2, 63);
        run(140);
        cyc(3'b011, 1'b0, 1'b0, 0, 0);
        run(70);

        // Asynchronous reset mid-period restores the default half-period.
        @(negedge clk_in);
        #2 rst_n = 1'b0;
        #1 chk_reset("reset_mid_period");
        model_reset();
        ch_en = '0; align = 1'b0; cfg_we = 1'b0;
        @(posedge clk_in);
        #1 chk_reset("reset_held");
        @(negedge clk_in);
        rst_n = 1'b1;
        run(30);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [N-1:0] en;
            for (int c = 0; c < N; c++) en[c] = ($urandom_range(7) != 0);
            cyc(en, ($urandom_range(63) == 0), ($urandom_range(7) == 0),
                int'($urandom_range(3)),
                ($urandom_range(7) == 0) ? 63 : int'($urandom_range(5)));
        end

        @(posedge clk_in);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
